// File: rtl/grid_renderer.sv
// Raster scanner for the 160x120 game grid: one pixel write per clock,
// with the player ship and enemy sprite drawn over bullet contents.
module grid_renderer #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int SHIP_W = 8,
   parameter int SHIP_H = 4,
   parameter int SHIP_Y = 112,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] BULLET_COLOUR = 3'b111,
   parameter logic [2:0] SHIP_COLOUR   = 3'b010,
   parameter logic [2:0] ENEMY_COLOUR  = 3'b100
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [WIDTH*HEIGHT-1:0]   grid,
   input  logic [7:0]                user_x,
   input  logic [7:0]                enemy_x,
   output logic [7:0]                x,
   output logic [6:0]                y,
   output logic [2:0]                colour,
   output logic                      plot,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t state, state_next;

   logic [7:0]  cx;
   logic [6:0]  cy;
   logic        row_end;
   logic        last;
   logic [14:0] idx;
   logic [8:0]  ship_end;
   logic [8:0]  enemy_end;
   logic        in_ship;
   logic        in_enemy;
   logic [2:0]  pix_colour;

   logic [7:0]  x_n;
   logic [6:0]  y_n;
   logic [2:0]  colour_n;
   logic        plot_n;
   logic        busy_n;
   logic        done_n;

   assign row_end = (cx == 8'(WIDTH - 1));
   assign last    = row_end && (cy == 7'(HEIGHT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cx <= '0;
         cy <= '0;
      end else if (state == IDLE && start) begin
         cx <= '0;
         cy <= '0;
      end else if (state == SCAN) begin
         if (row_end) begin
            cx <= '0;
            cy <= last ? 7'd0 : cy + 7'd1;
         end else begin
            cx <= cx + 8'd1;
         end
      end
   end

   // 9-bit right edges so sprites near column 255 never wrap to 0
   assign ship_end  = {1'b0, user_x} + 9'(SHIP_W);
   assign enemy_end = {1'b0, enemy_x} + 9'(SHIP_W);

   assign in_ship = (cy >= 7'(SHIP_Y)) && (cy < 7'(SHIP_Y + SHIP_H))
                 && (cx >= user_x) && ({1'b0, cx} < ship_end);

   assign in_enemy = (cy < 7'(SHIP_H))
                  && (cx >= enemy_x) && ({1'b0, cx} < enemy_end);

   assign idx = ({8'd0, cy} * 15'(WIDTH)) + {7'd0, cx};

   always_comb begin
      pix_colour = BG_COLOUR;
      if (in_ship)        pix_colour = SHIP_COLOUR;
      else if (in_enemy)  pix_colour = ENEMY_COLOUR;
      else if (grid[idx]) pix_colour = BULLET_COLOUR;
   end

   always_comb begin
      x_n      = x;
      y_n      = y;
      colour_n = colour;
      plot_n   = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      unique case (state)
         SCAN: begin
            x_n      = cx;
            y_n      = cy;
            colour_n = pix_colour;
            plot_n   = 1'b1;
            busy_n   = 1'b1;
         end
         DONE:    done_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         x      <= x_n;
         y      <= y_n;
         colour <= colour_n;
         plot   <= plot_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: captures each frame into a
// frame buffer and checks timing, ordering and sprite/grid colours.
module tb_grid_renderer;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [19199:0] grid;
   logic [7:0]     user_x;
   logic [7:0]     enemy_x;
   logic [7:0]     x;
   logic [6:0]     y;
   logic [2:0]     colour;
   logic           plot;
   logic           busy;
   logic           done;

   int vectors    = 0;
   int miscompares = 0;

   int plot_cnt, busy_cnt, done_cnt, order_err;
   int first_i, last_i, done_i;
   int first_x, first_y, last_x, last_y;
   int col_cnt [0:7];
   logic [2:0] fb [0:159][0:119];
   int pl_seen, dn_seen;

   grid_renderer dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .grid    (grid),
      .user_x  (user_x),
      .enemy_x (enemy_x),
      .x       (x),
      .y       (y),
      .colour  (colour),
      .plot    (plot),
      .busy    (busy),
      .done    (done)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // i = 0 is the first falling edge after the edge that samples start
   task automatic run_frame(input int inj1, input int inj2);
      int p;
      plot_cnt = 0; busy_cnt = 0; done_cnt = 0; order_err = 0;
      first_i = -1; last_i = -1; done_i = -1;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
      for (int c = 0; c < 8; c++) col_cnt[c] = 0;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) fb[i][j] = 3'bxxx;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 19210; i++) begin
         if (plot === 1'b1) begin
            if (first_i < 0) begin
               first_i = i; first_x = int'(x); first_y = int'(y);
            end
            last_i = i; last_x = int'(x); last_y = int'(y);
            p = plot_cnt;
            if (int'(x) != p % 160 || int'(y) != p / 160) order_err++;
            if (x < 8'd160 && y < 7'd120) fb[x][y] = colour;
            col_cnt[colour]++;
            plot_cnt++;
         end
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++; done_i = i;
         end
         start = (i == inj1 || i == inj2);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic frame_checks(input string tag);
      chk({tag, ".plot_cnt"},  plot_cnt, 19200);
      chk({tag, ".first_i"},   first_i, 1);
      chk({tag, ".last_i"},    last_i, 19200);
      chk({tag, ".order"},     order_err, 0);
      chk({tag, ".busy_cnt"},  busy_cnt, 19200);
      chk({tag, ".done_cnt"},  done_cnt, 1);
      chk({tag, ".done_i"},    done_i, 19201);
      chk({tag, ".first_x"},   first_x, 0);
      chk({tag, ".first_y"},   first_y, 0);
      chk({tag, ".last_x"},    last_x, 159);
      chk({tag, ".last_y"},    last_y, 119);
      chk({tag, ".busy_end"},  int'(busy), 0);
      chk({tag, ".x_hold"},    int'(x), 159);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; grid = '0;
      user_x = 8'd200; enemy_x = 8'd200;
      repeat (3) @(negedge clk);
      chk("rst.plot", int'(plot), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.done", int'(done), 0);
      chk("rst.x", int'(x), 0);
      reset = 1'b0;

      // reset abandons a frame at pixel 500 (x=20, y=3)
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (501) @(negedge clk);
      chk("mid.plot", int'(plot), 1);
      chk("mid.x", int'(x), 20);
      chk("mid.y", int'(y), 3);
      #2 reset = 1'b1;
      #1;
      chk("async.plot", int'(plot), 0);
      chk("async.busy", int'(busy), 0);
      chk("async.x", int'(x), 0);
      chk("async.y", int'(y), 0);
      @(negedge clk);
      chk("rst_next.plot", int'(plot), 0);
      chk("rst_next.colour", int'(colour), 0);
      reset = 1'b0;
      pl_seen = 0; dn_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (plot === 1'b1) pl_seen++;
         if (done === 1'b1) dn_seen++;
      end
      chk("post_rst.plot", pl_seen, 0);
      chk("post_rst.done", dn_seen, 0);

      // empty grid, sprites off-screen, stray starts mid-scan and in DONE
      run_frame(100, 19200);
      frame_checks("empty");
      chk("empty.nonbg", 19200 - col_cnt[0], 0);

      // single bullet at (30,50), index 8030
      grid[8030] = 1'b1;
      run_frame(-1, -1);
      frame_checks("bullet");
      chk("bullet.pix", int'(fb[30][50]), 7);
      chk("bullet.cnt7", col_cnt[7], 1);
      chk("bullet.nbr", int'(fb[31][50]), 0);

      // clipped player at 156, enemy at 10, bullet under ship at (157,113)
      grid = '0;
      grid[18237] = 1'b1;
      user_x = 8'd156; enemy_x = 8'd10;
      run_frame(-1, -1);
      frame_checks("sprite");
      chk("ship.tl", int'(fb[156][112]), 2);
      chk("ship.br", int'(fb[159][115]), 2);
      chk("ship.over_bullet", int'(fb[157][113]), 2);
      chk("ship.left_edge", int'(fb[155][112]), 0);
      chk("ship.below", int'(fb[156][116]), 0);
      chk("ship.nowrap0", int'(fb[0][112]), 0);
      chk("ship.nowrap3", int'(fb[3][115]), 0);
      chk("ship.cnt2", col_cnt[2], 16);
      chk("enemy.tl", int'(fb[10][0]), 4);
      chk("enemy.br", int'(fb[17][3]), 4);
      chk("enemy.right", int'(fb[18][0]), 0);
      chk("enemy.left", int'(fb[9][3]), 0);
      chk("enemy.row4", int'(fb[10][4]), 0);
      chk("enemy.cnt4", col_cnt[4], 32);
      chk("sprite.cnt7", col_cnt[7], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
